// File: rtl/vga_timing_gen_if.sv
// Raster position and sync bundle from the timing generator into the draw pipeline.
// All fields belong to the same pixel, so they can be consumed together without realignment.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters with blanking, sync and start strobes.
// Latency: every output registered, all fields aligned to the same pixel. Backpressure: none.
// Optional VGA_FRAME_CNT_EN adds a 16-bit completed-frame counter port.
module vga_timing_gen #(
  parameter int   H_ACTIVE  = 800,
  parameter int   H_FP      = 40,
  parameter int   H_SYNC    = 128,
  parameter int   H_BP      = 88,
  parameter int   V_ACTIVE  = 600,
  parameter int   V_FP      = 1,
  parameter int   V_SYNC    = 4,
  parameter int   V_BP      = 23,
  parameter logic HSYNC_POL = 1'b1,
  parameter logic VSYNC_POL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  vga_if.out   vga_out,
  output logic frame_start,
  output logic line_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 2048");
    end
  endgenerate

  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [11:0] H_BLNK  = 12'(H_ACTIVE);
  localparam logic [11:0] HS_BEG  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END  = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_BLNK  = 12'(V_ACTIVE);
  localparam logic [11:0] VS_BEG  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END  = 12'(V_ACTIVE + V_FP + V_SYNC);

  // Low for the first cycle after reset so that pixel (0,0) is shown before counting.
  logic        started;
  logic        h_wrap;
  logic [10:0] h_nxt;
  logic [10:0] v_nxt;
  logic        h_sync_win;
  logic        v_sync_win;

  always_comb begin
    h_nxt  = '0;
    v_nxt  = '0;
    h_wrap = (vga_out.hcount == H_LAST);
    if (started) begin
      h_nxt = h_wrap ? 11'd0 : vga_out.hcount + 11'd1;
      v_nxt = vga_out.vcount;
      if (h_wrap) begin
        v_nxt = (vga_out.vcount == V_LAST) ? 11'd0 : vga_out.vcount + 11'd1;
      end
    end
  end

  // Flags are derived from the next position so they land in the same cycle as the counters.
  assign h_sync_win = ({1'b0, h_nxt} >= HS_BEG) && ({1'b0, h_nxt} < HS_END);
  assign v_sync_win = ({1'b0, v_nxt} >= VS_BEG) && ({1'b0, v_nxt} < VS_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      started        <= 1'b0;
      vga_out.hcount <= '0;
      vga_out.vcount <= '0;
      vga_out.hblnk  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.hsync  <= ~HSYNC_POL;
      vga_out.vsync  <= ~VSYNC_POL;
      line_start     <= 1'b0;
      frame_start    <= 1'b0;
    end else begin
      started        <= 1'b1;
      vga_out.hcount <= h_nxt;
      vga_out.vcount <= v_nxt;
      vga_out.hblnk  <= ({1'b0, h_nxt} >= H_BLNK);
      vga_out.vblnk  <= ({1'b0, v_nxt} >= V_BLNK);
      vga_out.hsync  <= h_sync_win ? HSYNC_POL : ~HSYNC_POL;
      vga_out.vsync  <= v_sync_win ? VSYNC_POL : ~VSYNC_POL;
      line_start     <= (h_nxt == 11'd0);
      frame_start    <= (h_nxt == 11'd0) && (v_nxt == 11'd0);
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // The frame_start right after reset is not a completed frame, hence the started qualifier.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (started && h_nxt == 11'd0 && v_nxt == 11'd0) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 The block SHALL have parameters H_FP, H_SYNC, H_BP, defaults 40, 128, 88, horizontal front porch, sync and back porch in pixels.
REQ-003 The block SHALL have parameter V_ACTIVE, default 600, visible lines per frame.
REQ-004 The block SHALL have parameters V_FP, V_SYNC, V_BP, defaults 1, 4, 23, vertical front porch, sync and back porch in lines.
REQ-005 The block SHALL have parameters HSYNC_POL, VSYNC_POL, default 1, active level of the sync pulses.
REQ-006 Port clk, input, 1: pixel clock; all logic on its rising edge.
REQ-007 Port rst, input, 1: synchronous, active-high reset.
REQ-008 Port vga_out, vga_if.out: hcount 11 bits, vcount 11 bits, hsync, vsync, hblnk, vblnk, 1 bit each; source of the draw pipeline.
REQ-009 Port frame_start, output, 1: one-cycle strobe marking pixel (0,0).
REQ-010 Port line_start, output, 1: one-cycle strobe marking hcount==0 on every line.
REQ-011 Port frame_cnt, output, 16: frames completed since reset (present only with VGA_FRAME_CNT_EN).

Function
REQ-012 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP, elaborated as constants; both SHALL be at most 2048, otherwise elaboration fails.
REQ-013 hcount SHALL increment by 1 each cycle, wrapping from H_TOTAL-1 to 0.
REQ-014 vcount SHALL increment by 1 only in the cycle hcount wraps, wrapping from V_TOTAL-1 to 0 when hcount also wraps.
REQ-015 hblnk SHALL be 1 exactly when hcount >= H_ACTIVE; vblnk SHALL be 1 exactly when vcount >= V_ACTIVE.
REQ-016 hsync SHALL equal HSYNC_POL when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, else its inverse.
REQ-017 vsync SHALL equal VSYNC_POL when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, else its inverse; vsync changes only in cycles where hcount==0.
REQ-018 All outputs SHALL be registered; in every cycle all flags and strobes SHALL be consistent with the hcount/vcount presented in that same cycle (zero skew between fields).
REQ-019 line_start SHALL be 1 exactly when hcount==0; frame_start exactly when hcount==0 and vcount==0.
REQ-020 Counters SHALL use compare-to-terminal-value, never modulo-2^11 overflow.

Reset
REQ-021 While rst is 1: hcount=0, vcount=0, hblnk=0, vblnk=0, hsync=!HSYNC_POL, vsync=!VSYNC_POL, line_start=0, frame_start=0, frame_cnt=0.
REQ-022 The first cycle after rst deasserts SHALL present hcount=0, vcount=0 with frame_start=1 and line_start=1.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no partial sync pulse extension beyond the reset cycle.

Configuration
REQ-024 Macro VGA_FRAME_CNT_EN defined: frame_cnt SHALL increment by 1 (wrap at 65535->0) in the cycle after the last pixel of each frame, i.e. coincident with frame_start, except the first frame_start after reset, where it stays 0.
REQ-025 Macro VGA_FRAME_CNT_EN undefined: frame_cnt port and its register SHALL be absent; all other behaviour identical.

Verification
REQ-026 Release reset, run 2 frames -> hcount 0..1055 per line, vcount 0..627, exactly 663168 cycles between frame_start pulses.
REQ-027 Line 0 -> hblnk rises at hcount=800, hsync active for hcount 840..967 (128 cycles), hblnk falls at hcount=0 of line 1.
REQ-028 Frame scan -> vblnk 1 for vcount 600..627, vsync active for vcount 601..604 only, transitions only at hcount=0.
REQ-029 Assert rst for 3 cycles at hcount=900, vcount=602 -> outputs at reset values during reset, next cycle hcount=0, vcount=0, frame_start=1, sync pulses restart cleanly.
REQ-030 With VGA_FRAME_CNT_EN, run 3 frames -> frame_cnt 0,1,2 at successive frame_start; without macro -> build succeeds and ports REQ-008..010 match.
REQ-031 Override HSYNC_POL=0, VSYNC_POL=0, H_ACTIVE=640, H_FP=16, H_SYNC=96, H_BP=48 -> H_TOTAL 800, hsync low for hcount 656..751, high elsewhere.
